// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI responder with a small 8-bit register file.
//
// Each transaction is two 8-bit frames, sent MSB first: a command byte, then a
// data byte. In the command byte, bit 7 selects read (1) or write (0) and bits
// 6:0 give the register address. Both ends sample and shift on posedge SCK
// while SSB is low. The register file is also available in parallel on
// reg_bus.
//
// Ports:
//   SCK       - the only clock; all state changes on its rising edge
//   reset     - synchronous, active-low reset, sampled on posedge SCK
//   SSB       - active-low slave select from the master
//   MOSI      - serial data from the master
//   MISO      - serial data to the master; forced to 0 while SSB is high
//   reg_bus   - register file, register k at bits [8k+7:8k]
//   wr_pulse  - one-cycle pulse on the edge where a register write commits
//   wr_addr   - address of the last committed write; held until the next one
//   frame_err - one-cycle pulse when a partial frame is thrown away

module spi_reg_slave #(
   parameter int unsigned NUM_REGS = 4
) (
   input  logic                        SCK,
   input  logic                        reset,
   input  logic                        SSB,
   input  logic                        MOSI,
   output logic                        MISO,
   output logic [NUM_REGS*8-1:0]       reg_bus,
   output logic                        wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic                        frame_err
);

   localparam int unsigned ADDR_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      StCmd,
      StWrData,
      StRdData
   } state_t;

   state_t              r_state, w_state_d;
   logic [2:0]          r_bit_cnt, w_bit_cnt_d;
   logic [7:0]          r_shreg, w_shreg_d;
   logic [6:0]          r_addr, w_addr_d;
   logic [7:0]          r_regs [NUM_REGS];
   logic                r_wr_pulse, w_wr_pulse_d;
   logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_d;
   logic                r_frame_err, w_frame_err_d;

   logic                w_wr_en;
   logic [7:0]          w_byte;
   logic [7:0]          w_cmd_rdata;
   logic                w_wr_hit;

   // Byte seen on the edge that completes a frame
   assign w_byte = {r_shreg[6:0], MOSI};

   // Address decode. Addresses at or above NUM_REGS read as 0x00, and writes
   // to them are dropped.
   always_comb begin
      w_cmd_rdata = 8'h00;
      w_wr_hit    = 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (w_byte[6:0] == 7'(k)) begin
            w_cmd_rdata = r_regs[k];
         end
         if (r_addr == 7'(k)) begin
            w_wr_hit = 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d     = r_state;
      w_bit_cnt_d   = r_bit_cnt;
      w_shreg_d     = r_shreg;
      w_addr_d      = r_addr;
      w_wr_pulse_d  = 1'b0;
      w_wr_addr_d   = r_wr_addr;
      w_frame_err_d = 1'b0;
      w_wr_en       = 1'b0;

      if (!SSB) begin
         w_shreg_d   = w_byte;
         w_bit_cnt_d = r_bit_cnt + 3'd1;
         if (r_bit_cnt == 3'd7) begin
            unique case (r_state)
               StCmd: begin
                  w_addr_d = w_byte[6:0];
                  if (w_byte[7]) begin
                     // Preload read data so its MSB is on MISO before the
                     // first edge of the data frame
                     w_shreg_d = w_cmd_rdata;
                     w_state_d = StRdData;
                  end else begin
                     w_shreg_d = 8'h00;
                     w_state_d = StWrData;
                  end
               end
               StWrData: begin
                  if (w_wr_hit) begin
                     w_wr_en      = 1'b1;
                     w_wr_pulse_d = 1'b1;
                     w_wr_addr_d  = r_addr[ADDR_W-1:0];
                  end
                  w_shreg_d = 8'h00;
                  w_state_d = StCmd;
               end
               StRdData: begin
                  w_shreg_d = 8'h00;
                  w_state_d = StCmd;
               end
               default: begin
                  w_shreg_d = 8'h00;
                  w_state_d = StCmd;
               end
            endcase
         end
      end else if (r_bit_cnt != 3'd0) begin
         // SSB rose mid-frame: discard the partial frame and go back to the
         // command state
         w_bit_cnt_d   = 3'd0;
         w_shreg_d     = 8'h00;
         w_state_d     = StCmd;
         w_frame_err_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge SCK) begin
      if (!reset) begin
         r_state     <= StCmd;
         r_bit_cnt   <= 3'd0;
         r_shreg     <= 8'h00;
         r_addr      <= 7'd0;
         r_wr_pulse  <= 1'b0;
         r_wr_addr   <= '0;
         r_frame_err <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= 8'h00;
         end
      end else begin
         r_state     <= w_state_d;
         r_bit_cnt   <= w_bit_cnt_d;
         r_shreg     <= w_shreg_d;
         r_addr      <= w_addr_d;
         r_wr_pulse  <= w_wr_pulse_d;
         r_wr_addr   <= w_wr_addr_d;
         r_frame_err <= w_frame_err_d;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_wr_en && (r_addr == 7'(k))) begin
               r_regs[k] <= w_byte;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
      assign reg_bus[8*g +: 8] = r_regs[g];
   end

   assign MISO      = ~SSB & r_shreg[7];
   assign wr_pulse  = r_wr_pulse;
   assign wr_addr   = r_wr_addr;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: self-checking bench for spi_reg_slave (NUM_REGS = 4).
// A table of two-frame transactions with expected register-bus and pulse
// results is applied in a loop. Expected read bytes go through a queue. Short
// hand-written sequences cover aborted frames and a reset in mid-frame.

module tb_spi_reg_slave;

   logic        SCK = 1'b0;
   logic        reset;
   logic        SSB;
   logic        MOSI;
   logic        MISO;
   logic [31:0] reg_bus;
   logic        wr_pulse;
   logic [1:0]  wr_addr;
   logic        frame_err;

   spi_reg_slave #(
      .NUM_REGS(4)
   ) u_dut (
      .SCK      (SCK),
      .reset    (reset),
      .SSB      (SSB),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .reg_bus  (reg_bus),
      .wr_pulse (wr_pulse),
      .wr_addr  (wr_addr),
      .frame_err(frame_err)
   );

   always #5 SCK = ~SCK;

   int checks = 0;
   int errors = 0;

   // Running totals of pulses, sampled 1 time unit after each rising edge
   int tot_pulse = 0;
   int tot_err   = 0;
   int miso_hi   = 0;
   always @(posedge SCK) begin
      #1;
      if (wr_pulse === 1'b1) tot_pulse++;
      if (frame_err === 1'b1) tot_err++;
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  data;
      logic        gap;       // 1: SSB high between frames and after the transaction
      logic [31:0] exp_bus;
      int          exp_pulse;
      logic [1:0]  exp_waddr;
      logic [7:0]  exp_miso;  // byte the master should receive in the data frame
   } vec_t;

   vec_t       vecs [11];
   logic [7:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b, output logic m);
      @(negedge SCK);
      SSB  = 1'b0;
      MOSI = b;
      #1;
      m = MISO;
   endtask

   task automatic send_frame(input logic [7:0] tx, output logic [7:0] rx);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         drive_bit(tx[i], m);
         rx[i] = m;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge SCK);
         SSB  = 1'b1;
         MOSI = 1'b0;
         #1;
         if (MISO !== 1'b0) miso_hi++;
      end
   endtask

   // Wait until the last rising edge has been applied and sampled
   task automatic settle();
      @(posedge SCK);
      #2;
   endtask

   task automatic do_txn(input logic [7:0] cmd, input logic [7:0] data, input logic gap,
                         output logic [7:0] rx_c, output logic [7:0] rx_d);
      send_frame(cmd, rx_c);
      if (gap) idle(2);
      send_frame(data, rx_d);
      if (gap) idle(3);
      settle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rx_c, rx_d, exp_b;
      logic       m;
      int         p0, e0;

      //                cmd    data   gap   exp_bus        pls waddr miso
      vecs[0]  = '{8'h01, 8'h22, 1'b1, 32'h0000_2200, 1, 2'd1, 8'h00};
      vecs[1]  = '{8'h81, 8'h00, 1'b1, 32'h0000_2200, 0, 2'd1, 8'h22};
      vecs[2]  = '{8'h07, 8'hFF, 1'b1, 32'h0000_2200, 0, 2'd1, 8'h00};
      vecs[3]  = '{8'h87, 8'h00, 1'b1, 32'h0000_2200, 0, 2'd1, 8'h00};
      vecs[4]  = '{8'h03, 8'hC3, 1'b0, 32'hC300_2200, 1, 2'd3, 8'h00};
      vecs[5]  = '{8'h83, 8'h00, 1'b0, 32'hC300_2200, 0, 2'd3, 8'hC3};
      vecs[6]  = '{8'h00, 8'hA5, 1'b1, 32'hC300_22A5, 1, 2'd0, 8'h00};
      vecs[7]  = '{8'h80, 8'hFF, 1'b1, 32'hC300_22A5, 0, 2'd0, 8'hA5};
      vecs[8]  = '{8'h02, 8'h5A, 1'b1, 32'hC35A_22A5, 1, 2'd2, 8'h00};
      vecs[9]  = '{8'h82, 8'h00, 1'b1, 32'hC35A_22A5, 0, 2'd2, 8'h5A};
      vecs[10] = '{8'h83, 8'h00, 1'b1, 32'hC35A_22A5, 0, 2'd2, 8'hC3};

      reset = 1'b0;
      SSB   = 1'b1;
      MOSI  = 1'b0;
      repeat (3) @(negedge SCK);
      reset = 1'b1;
      settle();
      check("reset_bus", reg_bus, 32'h0);
      check("reset_waddr", {30'd0, wr_addr}, 32'd0);
      check("reset_pulse", {31'd0, wr_pulse}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      check("reset_miso", {31'd0, MISO}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         p0 = tot_pulse;
         e0 = tot_err;
         miso_hi = 0;
         exp_q.push_back(vecs[i].exp_miso);
         do_txn(vecs[i].cmd, vecs[i].data, vecs[i].gap, rx_c, rx_d);
         exp_b = exp_q.pop_front();
         check($sformatf("v%0d_cmd_miso", i), {24'd0, rx_c}, 32'h0);
         check($sformatf("v%0d_rd_data", i), {24'd0, rx_d}, {24'd0, exp_b});
         check($sformatf("v%0d_pulses", i), tot_pulse - p0, vecs[i].exp_pulse);
         check($sformatf("v%0d_ferr", i), tot_err - e0, 0);
         check($sformatf("v%0d_miso_gap", i), miso_hi, 0);
         check($sformatf("v%0d_bus", i), reg_bus, vecs[i].exp_bus);
         check($sformatf("v%0d_waddr", i), {30'd0, wr_addr}, {30'd0, vecs[i].exp_waddr});
      end

      // Abort in the command frame after 3 bits, then write register 2
      p0 = tot_pulse;
      e0 = tot_err;
      for (int i = 0; i < 3; i++) drive_bit(1'b0, m);
      idle(3);
      settle();
      check("abort_cmd_ferr", tot_err - e0, 1);
      check("abort_cmd_pulse", tot_pulse - p0, 0);
      p0 = tot_pulse;
      e0 = tot_err;
      do_txn(8'h02, 8'h3C, 1'b1, rx_c, rx_d);
      check("after_abort_bus", reg_bus, 32'hC33C_22A5);
      check("after_abort_pulse", tot_pulse - p0, 1);
      check("after_abort_waddr", {30'd0, wr_addr}, 32'd2);
      check("after_abort_ferr", tot_err - e0, 0);

      // Abort in the data frame of a write: nothing is written, then read back
      p0 = tot_pulse;
      e0 = tot_err;
      send_frame(8'h01, rx_c);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, m);
      idle(3);
      settle();
      check("abort_data_ferr", tot_err - e0, 1);
      check("abort_data_pulse", tot_pulse - p0, 0);
      check("abort_data_bus", reg_bus, 32'hC33C_22A5);
      exp_q.push_back(8'h22);
      do_txn(8'h81, 8'h00, 1'b1, rx_c, rx_d);
      exp_b = exp_q.pop_front();
      check("abort_data_readback", {24'd0, rx_d}, {24'd0, exp_b});

      // Reset at bit 4 of a data frame
      send_frame(8'h01, rx_c);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, m);
      @(negedge SCK);
      reset = 1'b0;
      SSB   = 1'b1;
      MOSI  = 1'b0;
      @(negedge SCK);
      reset = 1'b1;
      e0 = tot_err;
      idle(2);
      settle();
      check("midreset_bus", reg_bus, 32'h0);
      check("midreset_waddr", {30'd0, wr_addr}, 32'd0);
      check("midreset_ferr", tot_err - e0, 0);
      p0 = tot_pulse;
      do_txn(8'h00, 8'h11, 1'b1, rx_c, rx_d);
      check("postreset_bus", reg_bus, 32'h0000_0011);
      check("postreset_pulse", tot_pulse - p0, 1);
      check("postreset_waddr", {30'd0, wr_addr}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
SPI responder for the `spi_master` link: shares SCK, SSB, MOSI and MISO with the master. It decodes a two-frame transaction (command byte, then data byte), writes to or reads from a small 8-bit register file, and exposes the registers in parallel to the rest of the design. Mode matches the master: full duplex, MSB first, both ends sample and shift on posedge SCK while SSB=0.

Parameters:
NUM_REGS, 4, number of 8-bit registers (2..128).
ADDR_W, $clog2(NUM_REGS), width of wr_addr (derived, not overridden).

Ports:
SCK  input  1  sole clock; all state updates on posedge.
reset  input  1  synchronous, active-low; sampled on posedge SCK.
SSB  input  1  active-low slave select from master.
MOSI  input  1  serial data from master, sampled on posedge SCK when SSB=0.
MISO  output  1  serial data to master; = shreg[7] when SSB=0, 0 when SSB=1 (combinational gate).
reg_bus  output  NUM_REGS*8  register file, reg k at [8k+7:8k].
wr_pulse  output  1  one-cycle pulse on the edge a register write commits.
wr_addr  output  ADDR_W  address of last committed write; held until next write.
frame_err  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (reset=0 at posedge): state=CMD, bit_cnt=0, shreg=0x00, all regs=0x00, wr_pulse=0, wr_addr=0, frame_err=0, cmd latch=0x00. Reset has priority over everything, mid-frame included; the aborted frame has no effect.
- State machine: CMD, WR_DATA, RD_DATA.
- Posedge with SSB=0: shreg <= {shreg[6:0], MOSI}; bit_cnt increments 0..7. On the 8th edge (bit_cnt==7), the frame completes: byte = {shreg[6:0], MOSI}, bit_cnt wraps to 0.
- Frame complete in CMD:
  - byte[7]=1 means read, 0 means write; addr=byte[6:0], latched.
  - Read: shreg <= reg[addr] (0x00 if addr>=NUM_REGS); state goes to RD_DATA.
  - Write: shreg <= 0x00; state goes to WR_DATA.
- Frame complete in WR_DATA:
  - If addr<NUM_REGS: reg[addr] <= byte, wr_pulse=1 on that edge, wr_addr <= addr.
  - Out-of-range write is dropped silently (no pulse).
  - shreg <= 0x00; state goes to CMD.
- Frame complete in RD_DATA: MOSI byte ignored; shreg <= 0x00; state goes to CMD.
- Read latency: data byte appears on MISO MSB-first in the frame immediately after the command frame. The master captures bit7 at the first posedge of the data frame.
- Posedge with SSB=1:
  - If bit_cnt!=0 (partial frame): bit_cnt <= 0, shreg <= 0x00, state <= CMD, frame_err=1 for that cycle.
  - If bit_cnt==0: idle; state and shreg hold, so inter-frame gaps of any length are legal.
- SSB held low beyond 8 edges: frames run back-to-back; the next frame starts immediately with no gap required.
- wr_pulse and frame_err are registered and low on all other cycles; they never assert together.
- reg_bus updates on the same edge wr_pulse asserts.

Test Plan:
- Write 0x01 then 0x22, SSB high between frames with 2-3 idle edges: reg1=0x22 after 16th shift edge, wr_pulse high exactly 1 cycle, wr_addr=1, MISO=0 throughout.
- Read-back after that write: frames 0x81 then 0x00 → master receives 0x22 (MISO bits 0,0,1,0,0,0,1,0); reg_bus unchanged, no wr_pulse.
- Abort: SSB low for 3 edges of cmd 0x01, then high → frame_err 1 cycle. Following 0x02/0x5A writes reg2=0x5A only; reg1 untouched.
- Out of range (NUM_REGS=4): write 0x07/0xFF leaves all regs unchanged with no wr_pulse; read 0x87 returns 0x00.
- Back-to-back: SSB low for 16 continuous edges carrying 0x03,0xC3 → reg3=0xC3. Then 0x83,0x00 in 16 more continuous edges → MISO shifts 0xC3.
- Reset mid-data-frame: after cmd 0x01, assert reset=0 at bit 4 of the data frame → all regs 0, state CMD. Subsequent full 0x00/0x11 write gives reg0=0x11.
